// File: rtl/half_sub_if.sv
// Bundle of half_sub operand inputs and registered result outputs.
// The master side drives operands; the slave side is the subtractor.
interface half_sub_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] b0;
    logic             out_valid;
    logic             borrow_any;
    logic [CNT_W-1:0] borrow_cnt;

    // Handshake: in_valid qualifies a/b for one cycle; out_valid marks d/b0
    // as the result of the input accepted on the previous edge. No ready.
    modport master (
        output a, b, in_valid, clr,
        input  d, b0, out_valid, borrow_any, borrow_cnt
    );

    modport slave (
        input  a, b, in_valid, clr,
        output d, b0, out_valid, borrow_any, borrow_cnt
    );
endinterface

// File: rtl/half_sub.sv
// Registered bit-wise half subtractor with a sticky borrow flag and a
// saturating count of cycles in which any slice borrowed.
module half_sub #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input logic       clk,
    input logic       rst_n,
    half_sub_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] b0_q, b0_d;
    logic             out_valid_q, out_valid_d;
    logic             borrow_any_q, borrow_any_d;
    logic [CNT_W-1:0] borrow_cnt_q, borrow_cnt_d;

    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] b0_next;
    logic             borrow_hit;

    // Slices are independent: no borrow ripples between bits.
    assign d_next     = bus.a ^ bus.b;
    assign b0_next    = ~bus.a & bus.b;
    assign borrow_hit = bus.in_valid & (|b0_next);

    always_comb begin
        d_d          = d_q;
        b0_d         = b0_q;
        out_valid_d  = bus.in_valid;
        borrow_any_d = borrow_any_q;
        borrow_cnt_d = borrow_cnt_q;
        if (bus.in_valid) begin
            d_d  = d_next;
            b0_d = b0_next;
        end
        // clr takes priority over a borrow arriving on the same edge.
        if (bus.clr) begin
            borrow_any_d = 1'b0;
            borrow_cnt_d = '0;
        end else if (borrow_hit) begin
            borrow_any_d = 1'b1;
            if (borrow_cnt_q != CNT_MAX) begin
                borrow_cnt_d = borrow_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q          <= '0;
            b0_q         <= '0;
            out_valid_q  <= 1'b0;
            borrow_any_q <= 1'b0;
            borrow_cnt_q <= '0;
        end else begin
            d_q          <= d_d;
            b0_q         <= b0_d;
            out_valid_q  <= out_valid_d;
            borrow_any_q <= borrow_any_d;
            borrow_cnt_q <= borrow_cnt_d;
        end
    end

    assign bus.d          = d_q;
    assign bus.b0         = b0_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.borrow_any = borrow_any_q;
    assign bus.borrow_cnt = borrow_cnt_q;
endmodule

// File: tb/tb_half_sub.sv
// Bench for half_sub: a WIDTH=4/CNT_W=8 instance and a WIDTH=1/CNT_W=2
// instance share stimulus (the narrow one sees bit 0 of the operands).
module tb_half_sub;
    logic clk;
    logic rst_n;

    half_sub_if #(.WIDTH(4), .CNT_W(8)) bus4 ();
    half_sub_if #(.WIDTH(1), .CNT_W(2)) bus1 ();

    half_sub #(.WIDTH(4), .CNT_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    half_sub #(.WIDTH(1), .CNT_W(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word: {d4,b04,ov4,any4,cnt4[7:0], d1,b01,ov1,any1,cnt1[1:0]}
    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic        v;
        logic        c;
        logic [23:0] exp;
    } vec_t;

    localparam int NVEC = 20;
    vec_t        vecs[NVEC];
    logic [23:0] exp_q[$];
    int          checks;
    int          failures;

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b,
                                input logic v, input logic c,
                                input logic [3:0] d4, input logic [3:0] b04,
                                input logic ov4, input logic any4, input logic [7:0] cnt4,
                                input logic d1, input logic b01,
                                input logic ov1, input logic any1, input logic [1:0] cnt1);
        vec_t r;
        r.a   = a;
        r.b   = b;
        r.v   = v;
        r.c   = c;
        r.exp = {d4, b04, ov4, any4, cnt4, d1, b01, ov1, any1, cnt1};
        return r;
    endfunction

    function automatic logic [23:0] actual();
        return {bus4.d, bus4.b0, bus4.out_valid, bus4.borrow_any, bus4.borrow_cnt,
                bus1.d, bus1.b0, bus1.out_valid, bus1.borrow_any, bus1.borrow_cnt};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic v, input logic c);
        bus4.a = a;          bus4.b = b;          bus4.in_valid = v; bus4.clr = c;
        bus1.a = a[0:0];     bus1.b = b[0:0];     bus1.in_valid = v; bus1.clr = c;
    endtask

    task automatic apply(input string name, input vec_t r);
        logic [23:0] e;
        logic [23:0] act;
        @(negedge clk);
        drive(r.a, r.b, r.v, r.c);
        exp_q.push_back(r.exp);
        @(posedge clk);
        #1;
        act = actual();
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, " u4"}, {act[23:6], 6'd0}, {e[23:6], 6'd0});
            check({name, " u1"}, {18'd0, act[5:0]}, {18'd0, e[5:0]});
        end
    endtask

    // ---------------- test ----------------
    initial begin
        checks   = 0;
        failures = 0;
        //                a        b        v  c   d4       b04      ov any cnt4  d1 b01 ov any cnt1
        vecs[0]  = mk(4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 1, 0, 8'd0, 0, 0, 1, 0, 2'd0);
        vecs[1]  = mk(4'b0001, 4'b0000, 1, 0, 4'b0001, 4'b0000, 1, 0, 8'd0, 1, 0, 1, 0, 2'd0);
        vecs[2]  = mk(4'b0000, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1, 1, 8'd1, 1, 1, 1, 1, 2'd1);
        vecs[3]  = mk(4'b0001, 4'b0001, 1, 0, 4'b0000, 4'b0000, 1, 1, 8'd1, 0, 0, 1, 1, 2'd1);
        vecs[4]  = mk(4'b0001, 4'b0000, 1, 0, 4'b0001, 4'b0000, 1, 1, 8'd1, 1, 0, 1, 1, 2'd1);
        vecs[5]  = mk(4'b0000, 4'b0001, 0, 0, 4'b0001, 4'b0000, 0, 1, 8'd1, 1, 0, 0, 1, 2'd1);
        vecs[6]  = mk(4'b0101, 4'b0011, 1, 0, 4'b0110, 4'b0010, 1, 1, 8'd2, 0, 0, 1, 1, 2'd1);
        vecs[7]  = mk(4'b0000, 4'b0000, 0, 1, 4'b0110, 4'b0010, 0, 0, 8'd0, 0, 0, 0, 0, 2'd0);
        vecs[8]  = mk(4'b0000, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1, 1, 8'd1, 1, 1, 1, 1, 2'd1);
        vecs[9]  = mk(4'b0000, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1, 1, 8'd2, 1, 1, 1, 1, 2'd2);
        vecs[10] = mk(4'b0000, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1, 1, 8'd3, 1, 1, 1, 1, 2'd3);
        vecs[11] = mk(4'b0000, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1, 1, 8'd4, 1, 1, 1, 1, 2'd3);
        vecs[12] = mk(4'b0000, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1, 1, 8'd5, 1, 1, 1, 1, 2'd3);
        vecs[13] = mk(4'b0000, 4'b1111, 1, 0, 4'b1111, 4'b1111, 1, 1, 8'd6, 1, 1, 1, 1, 2'd3);
        vecs[14] = mk(4'b1111, 4'b0000, 1, 0, 4'b1111, 4'b0000, 1, 1, 8'd6, 1, 0, 1, 1, 2'd3);
        vecs[15] = mk(4'b0000, 4'b0000, 0, 1, 4'b1111, 4'b0000, 0, 0, 8'd0, 1, 0, 0, 0, 2'd0);
        vecs[16] = mk(4'b0000, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1, 1, 8'd1, 1, 1, 1, 1, 2'd1);
        vecs[17] = mk(4'b0000, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1, 1, 8'd2, 1, 1, 1, 1, 2'd2);
        vecs[18] = mk(4'b0000, 4'b0001, 1, 1, 4'b0001, 4'b0001, 1, 0, 8'd0, 1, 1, 1, 0, 2'd0);
        vecs[19] = mk(4'b1000, 4'b0100, 1, 0, 4'b1100, 4'b0100, 1, 1, 8'd1, 0, 0, 1, 0, 2'd0);

        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", actual(), 24'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply($sformatf("vec_%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges while out_valid is high.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", actual(), 24'd0);
        drive(4'b0000, 4'b0001, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", actual(), 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 4'b0001, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("released_idle", actual(), 24'd0);
        apply("first_valid_after_reset",
              mk(4'b0001, 4'b0000, 1, 0, 4'b0001, 4'b0000, 1, 0, 8'd0, 1, 0, 1, 0, 2'd0));

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/half_sub.md
Name: half_sub

Overview:
- Bit-wise half subtractor: per bit, d = a XOR b (difference) and b0 = (NOT a) AND b (borrow out).
- Registered variant with one clock and an asynchronous active-low reset.
- Adds a valid flag, a sticky any-borrow flag and a saturating borrow event counter.
- Serves as a leaf arithmetic cell for subtractor chains and datapath test logic.

Parameters:
- WIDTH, 1, number of independent half-subtractor bit slices (≥1).
- CNT_W, 8, width of the borrow event counter (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- a  input  WIDTH  minuend bits.
- b  input  WIDTH  subtrahend bits.
- in_valid  input  1  a/b are valid this cycle.
- clr  input  1  synchronous clear of the sticky flag and counter.
- d  output  WIDTH  registered difference, a XOR b.
- b0  output  WIDTH  registered borrow, ~a & b.
- out_valid  output  1  d/b0 hold the result of a valid input.
- borrow_any  output  1  sticky flag: any borrow seen since reset or clr.
- borrow_cnt  output  CNT_W  saturating count of valid cycles with |b0_next != 0.

Behaviour:
- Reset (rst_n=0, asynchronous): d=0, b0=0, out_valid=0, borrow_any=0, borrow_cnt=0. All outputs hold these values while rst_n is low.
- Per bit i, combinational:
  - d_next[i] = a[i] ^ b[i]
  - b0_next[i] = ~a[i] & b[i]
  - Truth table (a,b → d,b0): 00→0,0; 10→1,0; 01→1,1; 11→0,0.
- Bit slices are independent. There is no borrow chaining between bits.
- Latency is 1 cycle. On a rising clk edge with in_valid=1:
  - d←d_next, b0←b0_next, out_valid←1.
- On a rising clk edge with in_valid=0:
  - d and b0 hold their previous values; out_valid←0.
- borrow_any:
  - Set on an edge where in_valid=1 and |b0_next=1.
  - Cleared on an edge where clr=1.
- borrow_cnt:
  - Increments by 1 on an edge where in_valid=1 and |b0_next=1.
  - Saturates at 2^CNT_W−1 with no wrap-around.
  - Reset to 0 on an edge where clr=1.
- clr together with a borrowing valid input on the same edge: clr wins. borrow_any=0 and borrow_cnt=0 after the edge; d/b0/out_valid still update normally.
- Reset asserted mid-operation overrides everything immediately. The first valid input after release produces out_valid one cycle later.
- No X-propagation masking: X on a/b while in_valid=1 propagates to d/b0.
- No backpressure. The block accepts an input every cycle.

Test Plan:
- Exhaustive WIDTH=1 sweep: pairs (a,b)=(0,0),(1,0),(0,1),(1,1) with in_valid=1 on consecutive cycles → one cycle later d=0,1,1,0 and b0=0,0,1,0; out_valid=1 each cycle; borrow_cnt ends at 1; borrow_any=1.
- Hold check: apply a=1,b=0 valid, then in_valid=0 with a=0,b=1 → d stays 1, b0 stays 0, out_valid drops to 0, borrow_cnt unchanged.
- WIDTH=4: a=4'b0101, b=4'b0011, valid → d=4'b0110, b0=4'b0010, borrow_cnt+1.
- Saturation with CNT_W=2: 5 consecutive valid cycles of a=0,b=1 → borrow_cnt reads 1,2,3,3,3.
- clr priority: with borrow_cnt=2, apply clr=1 together with valid a=0,b=1 → after the edge borrow_cnt=0, borrow_any=0, d=1, b0=1, out_valid=1.
- Async reset: assert rst_n=0 between clock edges while out_valid=1 → all outputs go to 0 immediately without waiting for clk, and stay 0 until the first valid edge after release.
